// File: rtl/gates_arbiter_pkg.sv
// gates_arbiter_pkg: shared encodings for the gates arbiter slice.
//   - Op encodings carried on op_in per requester.
//   - FSM state encoding used by gates_arbiter.
package gates_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/gates_rr_pick.sv
// gates_rr_pick: combinational round-robin picker.
//   req   in  NREQ  request vector
//   ptr   in  IDW   index with highest priority this round
//   valid out 1     at least one request present
//   idx   out IDW   first set request searching ptr, ptr+1, ... mod NREQ
module gates_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  // Walk the circular order backwards so the earliest hit from ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end else begin
        k = k;
      end
      if (req[k]) begin
        valid = 1'b1;
        idx   = k[IDW-1:0];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/gates_arbiter.sv
// gates_arbiter: round-robin arbiter/sequencer sharing one Gates unit
// (AND/OR/NOT) among NREQ requesters. One transaction every 3 cycles:
// IDLE (grant + operand latch) -> EXEC (capture result) -> RESP (pulse).
//   clk, rst          clock, synchronous active-high reset
//   req, a_in, b_in,  per-requester request, operands and op
//   op_in
//   gnt, rsp_valid,   one-cycle completion pulse, served id, result
//   rsp_id, rsp_data
//   gu_a, gu_b        registered operands to the shared Gates unit
//   gu_and/or/not     results from the shared Gates unit
// Optional build macro GATES_ARB_XOR_EN: op 11 returns A XOR B formed
// from the shared unit outputs; otherwise op 11 returns 0.
module gates_arbiter
  import gates_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 1,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ*2-1:0] op_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic [W-1:0]      gu_a,
  output logic [W-1:0]      gu_b,
  input  logic [W-1:0]      gu_and,
  input  logic [W-1:0]      gu_or,
  input  logic [W-1:0]      gu_not
);

  state_t           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   idx_r;
  logic [1:0]       op_r;
  logic             pick_valid_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [W-1:0]     result_s;

  gates_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Select the shared unit output that matches the latched op.
  always_comb begin
    result_s = {W{1'b0}};
    case (op_r)
      OP_AND: result_s = gu_and;
      OP_OR:  result_s = gu_or;
      OP_NOT: result_s = gu_not;
      OP_RSV: begin
`ifdef GATES_ARB_XOR_EN
        result_s = gu_or & ~gu_and;
`else
        result_s = {W{1'b0}};
`endif
      end
      default: result_s = {W{1'b0}};
    endcase
  end

  // Arbiter FSM: grant and latch in IDLE, capture in EXEC, retire in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= {IDW{1'b0}};
      idx_r     <= {IDW{1'b0}};
      op_r      <= OP_AND;
      gnt       <= {NREQ{1'b0}};
      rsp_valid <= 1'b0;
      rsp_id    <= {IDW{1'b0}};
      rsp_data  <= {W{1'b0}};
      gu_a      <= {W{1'b0}};
      gu_b      <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          gnt       <= {NREQ{1'b0}};
          rsp_valid <= 1'b0;
          if (pick_valid_s) begin
            idx_r   <= pick_idx_s;
            op_r    <= op_in[{pick_idx_s, 1'b0} +: 2];
            gu_a    <= a_in[pick_idx_s*W +: W];
            gu_b    <= b_in[pick_idx_s*W +: W];
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          rsp_data  <= result_s;
          rsp_id    <= idx_r;
          rsp_valid <= 1'b1;
          gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << idx_r;
          state_r   <= RESP;
        end
        RESP: begin
          gnt       <= {NREQ{1'b0}};
          rsp_valid <= 1'b0;
          // Served requester drops to lowest priority next round.
          ptr_r     <= (idx_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : idx_r + {{(IDW-1){1'b0}}, 1'b1};
          state_r   <= IDLE;
        end
        default: begin
          gnt       <= {NREQ{1'b0}};
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gates_arbiter.sv
// tb_gates_arbiter: table-driven directed vectors plus randomized traffic
// checked against a behavioural round-robin / gate model.
module tb_gates_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 1;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ*2-1:0] op_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [W-1:0]      gu_a;
  logic [W-1:0]      gu_b;
  logic [W-1:0]      gu_and;
  logic [W-1:0]      gu_or;
  logic [W-1:0]      gu_not;

  int n_checks;
  int n_fail;
  int m_ptr;

  // Shared Gates unit behavioural stand-in.
  assign gu_and = gu_a & gu_b;
  assign gu_or  = gu_a | gu_b;
  assign gu_not = ~gu_a;

  gates_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .gu_a      (gu_a),
    .gu_b      (gu_b),
    .gu_and    (gu_and),
    .gu_or     (gu_or),
    .gu_not    (gu_not)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [NREQ-1:0] r;
    logic [3:0]      a;
    logic [3:0]      b;
    logic [7:0]      op;
    bit              chg;
    int              exp_id;
    int              exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First requester in circular order starting at p.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic int model_gate(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return (a == 0) ? 1 : 0;
`ifdef GATES_ARB_XOR_EN
      3: return a ^ b;
`else
      3: return 0;
`endif
      default: return 0;
    endcase
  endfunction

  // One transaction starting with the DUT in IDLE, lockstep timing check.
  task automatic do_txn(input string name, input logic [NREQ-1:0] r, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] op, input bit chg,
                        input int exp_id, input int exp_data);
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[exp_id] = 1'b1;
    req = r; a_in = a; b_in = b; op_in = op;
    tick();  // grant decision edge
    check({name, " gnt_exec"}, 32'(gnt), 32'd0);
    check({name, " vld_exec"}, 32'(rsp_valid), 32'd0);
    check({name, " gu_a"}, 32'(gu_a), 32'(a[exp_id]));
    check({name, " gu_b"}, 32'(gu_b), 32'(b[exp_id]));
    if (chg) begin
      a_in = ~a_in; b_in = ~b_in; op_in = ~op_in;
    end
    tick();  // completion pulse two edges after the request edge
    check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check({name, " vld"}, 32'(rsp_valid), 32'd1);
    check({name, " id"}, 32'(rsp_id), 32'(exp_id));
    check({name, " data"}, 32'(rsp_data), 32'(exp_data));
    req[exp_id] = 1'b0;
    tick();
    check({name, " gnt_end"}, 32'(gnt), 32'd0);
    check({name, " vld_end"}, 32'(rsp_valid), 32'd0);
    check({name, " id_hold"}, 32'(rsp_id), 32'(exp_id));
    check({name, " data_hold"}, 32'(rsp_data), 32'(exp_data));
    m_ptr = (exp_id + 1) % NREQ;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; op_in = '0;

    // Contention: ops r3 NOT, r2 OR, r1 AND, r0 OR; a=1010 b=0110.
    vecs.push_back('{"c0", 4'b1111, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 0, 0});
    vecs.push_back('{"c1", 4'b1110, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 1, 1});
    vecs.push_back('{"c2", 4'b1100, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 2, 1});
    vecs.push_back('{"c3", 4'b1000, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 3, 0});
    // Single requester 0, AND truth table.
    vecs.push_back('{"and00", 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0, 0, 0});
    vecs.push_back('{"and01", 4'b0001, 4'b0000, 4'b0001, 8'h00, 1'b0, 0, 0});
    vecs.push_back('{"and10", 4'b0001, 4'b0001, 4'b0000, 8'h00, 1'b0, 0, 0});
    vecs.push_back('{"and11", 4'b0001, 4'b0001, 4'b0001, 8'h00, 1'b0, 0, 1});
    // Requester 2 OR / NOT / reserved.
    vecs.push_back('{"or2",  4'b0100, 4'b0100, 4'b0000, 8'b00_01_00_00, 1'b0, 2, 1});
    vecs.push_back('{"not2", 4'b0100, 4'b0100, 4'b0000, 8'b00_10_00_00, 1'b0, 2, 0});
`ifdef GATES_ARB_XOR_EN
    vecs.push_back('{"rsv10", 4'b0100, 4'b0100, 4'b0000, 8'b00_11_00_00, 1'b0, 2, 1});
`else
    vecs.push_back('{"rsv10", 4'b0100, 4'b0100, 4'b0000, 8'b00_11_00_00, 1'b0, 2, 0});
`endif
    vecs.push_back('{"rsv11", 4'b0100, 4'b0100, 4'b0100, 8'b00_11_00_00, 1'b0, 2, 0});
    // Operand change after grant: requester 1, leaves ptr at 2.
    vecs.push_back('{"chg1", 4'b0010, 4'b0010, 4'b0010, 8'h00, 1'b1, 1, 1});
    // Contention from ptr=2.
    vecs.push_back('{"d2", 4'b1111, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 2, 1});
    vecs.push_back('{"d3", 4'b1011, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 3, 0});
    vecs.push_back('{"d0", 4'b0011, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 0, 0});
    vecs.push_back('{"d1", 4'b0010, 4'b1010, 4'b0110, 8'b10_01_00_01, 1'b0, 1, 1});

    tick();
    tick();
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst vld", 32'(rsp_valid), 32'd0);
    check("rst id", 32'(rsp_id), 32'd0);
    check("rst data", 32'(rsp_data), 32'd0);
    check("rst gu_a", 32'(gu_a), 32'd0);
    check("rst gu_b", 32'(gu_b), 32'd0);
    rst = 1'b0;
    tick();
    check("idle gnt", 32'(gnt), 32'd0);

    foreach (vecs[i]) begin
      do_txn(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op,
             vecs[i].chg, vecs[i].exp_id, vecs[i].exp_data);
    end

    // Reset during EXEC: requester 1 granted, then discarded.
    req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010; op_in = 8'h00;
    tick();
    check("pre_rst gu_a", 32'(gu_a), 32'd1);
    rst = 1'b1;
    req = '0;
    tick();
    check("mid_rst gnt", 32'(gnt), 32'd0);
    check("mid_rst vld", 32'(rsp_valid), 32'd0);
    check("mid_rst id", 32'(rsp_id), 32'd0);
    check("mid_rst data", 32'(rsp_data), 32'd0);
    check("mid_rst gu_a", 32'(gu_a), 32'd0);
    check("mid_rst gu_b", 32'(gu_b), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    tick();
    check("post_rst gnt", 32'(gnt), 32'd0);
    check("post_rst vld", 32'(rsp_valid), 32'd0);
    // ptr back at 0: requester 0 beats 3, then 3 alone.
    do_txn("post_rst r0", 4'b1001, 4'b0001, 4'b0001, 8'h00, 1'b0, 0, 1);
    do_txn("post_rst r3", 4'b1000, 4'b1000, 4'b0000, 8'b01_00_00_00, 1'b0, 3, 1);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      logic [NREQ-1:0] r;
      logic [3:0]      a;
      logic [3:0]      b;
      logic [7:0]      op;
      int              id;
      int              d;
      r  = 4'($urandom_range(1, 15));
      a  = 4'($urandom);
      b  = 4'($urandom);
      op = 8'($urandom);
      id = model_pick(r, m_ptr);
      d  = model_gate(int'(op[2*id +: 2]), int'(a[id]), int'(b[id]));
      do_txn("rand", r, a, b, op, 1'($urandom), id, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
